// File: rtl/booth_pkg.sv
// Shared defaults and FSM state encoding for the Booth MAC accumulator slice.
package booth_pkg;

  localparam int ACC_W_DEF     = 80;
  localparam int MAX_TERMS_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } mac_state_t;

endpackage

// File: rtl/mac_sat_add.sv
// Combinational sign-extend and add of a 64-bit product into the accumulator.
// Define MAC_SAT_EN to clamp on signed overflow; otherwise the sum wraps.
module mac_sat_add #(
  parameter int ACC_W = 80
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [63:0]      prod,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] raw;

  assign ext = ACC_W'($signed(prod));
  assign raw = acc + ext;

`ifdef MAC_SAT_EN
  logic ovf_raw;

  // Overflow only when both operands share a sign that the result lost.
  assign ovf_raw = (acc[ACC_W-1] == ext[ACC_W-1]) && (raw[ACC_W-1] != acc[ACC_W-1]);

  always_comb begin
    sum = raw;
    if (ovf_raw) begin
      sum = acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  assign ovf = ovf_raw;
`else
  assign sum = raw;
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/booth_mac_accum.sv
// Accumulates signed 32x32 products per group and holds the result for a valid/ready consumer.
// Saturating arithmetic is enabled by defining MAC_SAT_EN.
//
// state | meaning
// IDLE  | acc and count zero, waiting for the first product of a group
// ACCUM | group open, summing products as they arrive
// HOLD  | result presented on out_*, input stalled until out_ready
module booth_mac_accum
  import booth_pkg::*;
#(
  parameter  int ACC_W     = ACC_W_DEF,
  parameter  int MAX_TERMS = MAX_TERMS_DEF,
  localparam int CNT_W     = $clog2(MAX_TERMS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  mac_state_t       state, state_nx;
  logic [ACC_W-1:0] acc, acc_nx, sum;
  logic [CNT_W-1:0] count, cnt_nx, cnt_inc;
  logic             ovf, ovf_nx, add_ovf;
  logic             rdy_q;
  logic             accept;

  mac_sat_add #(.ACC_W(ACC_W)) u_add (
    .acc  (acc),
    .prod (in_prod),
    .sum  (sum),
    .ovf  (add_ovf)
  );

  // rdy_q keeps in_ready low until the first edge after reset release.
  assign in_ready  = rdy_q && (state != HOLD) && !clr;
  assign accept    = in_valid && in_ready;
  assign cnt_inc   = count + CNT_W'(1);
  assign out_valid = (state == HOLD);
  assign out_acc   = acc;
  assign out_count = count;
  assign out_ovf   = ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      count <= cnt_nx;
      ovf   <= ovf_nx;
      rdy_q <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = count;
    ovf_nx   = ovf;
    if (clr) begin
      state_nx = IDLE;
      acc_nx   = '0;
      cnt_nx   = '0;
      ovf_nx   = 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            acc_nx   = sum;
            cnt_nx   = cnt_inc;
            ovf_nx   = ovf | add_ovf;
            state_nx = (in_last || (cnt_inc == CNT_W'(MAX_TERMS))) ? HOLD : ACCUM;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_nx = IDLE;
            acc_nx   = '0;
            cnt_nx   = '0;
            ovf_nx   = 1'b0;
          end
        end
        default: begin
          state_nx = IDLE;
          acc_nx   = '0;
          cnt_nx   = '0;
          ovf_nx   = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mac_accum.sv
// Scoreboard bench for booth_mac_accum: an 80-bit and a 64-bit instance share one stimulus stream.
module tb_booth_mac_accum;

`ifdef MAC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_prod = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, out_ovf;
  logic [79:0] out_acc;
  logic [4:0]  out_count;
  logic        in_ready64, out_valid64, out_ovf64;
  logic [63:0] out_acc64;
  logic [4:0]  out_count64;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [79:0] a80;
    logic [63:0] a64;
    logic [4:0]  cnt;
    logic        o80;
    logic        o64;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  booth_mac_accum dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_count(out_count), .out_ovf(out_ovf)
  );

  booth_mac_accum #(.ACC_W(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready64),
    .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid64), .out_ready(out_ready),
    .out_acc(out_acc64), .out_count(out_count64), .out_ovf(out_ovf64)
  );

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_result(input logic [79:0] a80, input logic [63:0] a64,
                               input logic [4:0] cnt, input logic o80, input logic o64);
    exp_t e;
    e.a80 = a80; e.a64 = a64; e.cnt = cnt; e.o80 = o80; e.o64 = o64;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [63:0] p, input logic l);
    in_valid = 1'b1; in_prod = p; in_last = l;
    @(negedge clk);
    chk("send_in_ready", 80'(in_ready), 80'(1));
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"},  80'(in_ready),   80'(0));
    chk({tag, "_out_valid"}, 80'(out_valid),  80'(0));
    chk({tag, "_out_acc"},   out_acc,         80'(0));
    chk({tag, "_out_count"}, 80'(out_count),  80'(0));
    chk({tag, "_out_ovf"},   80'(out_ovf),    80'(0));
    chk({tag, "_acc64"},     80'(out_acc64),  80'(0));
    chk({tag, "_ready64"},   80'(in_ready64), 80'(0));
  endtask

  // Monitor: each completed out handshake pops and checks one expected result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got acc %h count %0d with nothing expected", out_acc, out_count);
        end else begin
          e = exp_q.pop_front();
          chk("res_acc80",   out_acc,              e.a80);
          chk("res_count80", 80'(out_count),       80'(e.cnt));
          chk("res_ovf80",   80'(out_ovf),         80'(e.o80));
          chk("res_valid64", 80'(out_valid64),     80'(1));
          chk("res_acc64",   80'(out_acc64),       80'(e.a64));
          chk("res_count64", 80'(out_count64),     80'(e.cnt));
          chk("res_ovf64",   80'(out_ovf64),       80'(e.o64));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    chk("ready_before_edge", 80'(in_ready), 80'(0));
    @(posedge clk); #1;
    chk("ready_after_edge", 80'(in_ready), 80'(1));

    // 6, -4, 10 with last
    expect_result(80'd12, 64'd12, 5'd3, 1'b0, 1'b0);
    send(64'd6, 1'b0);
    send(64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    chk("g1_valid_before_last", 80'(out_valid), 80'(0));
    send(64'd10, 1'b1);
    chk("g1_latency_valid", 80'(out_valid), 80'(1));
    chk("g1_latency_count", 80'(out_count), 80'(3));
    chk("g1_hold_ready",    80'(in_ready),  80'(0));
    @(posedge clk); #1;
    chk("g1_back_idle", 80'(out_valid), 80'(0));

    // 16 products, no last: auto HOLD at MAX_TERMS
    expect_result(80'h0003_FFFF_FFF0_0000_0010,
                  SAT ? 64'h7FFF_FFFF_FFFF_FFFF : 64'hFFFF_FFF0_0000_0010,
                  5'd16, 1'b0, SAT);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("g2_valid_before_16", 80'(out_valid), 80'(0));
      send(64'h3FFF_FFFF_0000_0001, 1'b0);
    end
    chk("g2_auto_hold", 80'(out_valid), 80'(1));
    chk("g2_count",     80'(out_count), 80'(16));
    @(posedge clk); #1;

    // Back-pressure in HOLD for 5 cycles
    out_ready = 1'b0;
    expect_result(80'd99, 64'd99, 5'd2, 1'b0, 1'b0);
    send(64'd100, 1'b0);
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    in_valid = 1'b1; in_prod = 64'd5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready",  80'(in_ready),  80'(0));
      chk("bp_out_valid", 80'(out_valid), 80'(1));
      chk("bp_out_acc",   out_acc,        80'd99);
      chk("bp_out_count", 80'(out_count), 80'(2));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_released_idle", 80'(out_valid), 80'(0));
    chk("bp_released_acc",  out_acc,        80'd0);
    expect_result(80'd7, 64'd7, 5'd1, 1'b0, 1'b0);
    send(64'd7, 1'b1);
    @(posedge clk); #1;

    // clr mid-group with in_valid high
    send(64'd3, 1'b0);
    send(64'd4, 1'b0);
    in_valid = 1'b1; in_prod = 64'd50; clr = 1'b1;
    @(negedge clk);
    chk("clr_in_ready", 80'(in_ready), 80'(0));
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    chk("clr_out_valid", 80'(out_valid), 80'(0));
    chk("clr_out_acc",   out_acc,        80'd0);
    chk("clr_out_count", 80'(out_count), 80'(0));
    repeat (3) @(posedge clk);
    #1;
    chk("clr_still_idle", 80'(out_valid), 80'(0));
    expect_result(80'd8, 64'd8, 5'd1, 1'b0, 1'b0);
    send(64'd8, 1'b1);
    @(posedge clk); #1;

    // Signed overflow boundary: max positive then +1
    expect_result(80'h0000_8000_0000_0000_0000,
                  SAT ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h8000_0000_0000_0000,
                  5'd2, 1'b0, SAT);
    send(64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
    send(64'd1, 1'b1);
    @(posedge clk); #1;
    expect_result(80'hFFFF_FFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFFB, 5'd1, 1'b0, 1'b0);
    send(64'hFFFF_FFFF_FFFF_FFFB, 1'b1);
    @(posedge clk); #1;

    // Asynchronous reset in ACCUM
    send(64'd9, 1'b0);
    send(64'd9, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst2_ready_before_edge", 80'(in_ready), 80'(0));
    @(posedge clk); #1;
    chk("rst2_ready_after_edge", 80'(in_ready), 80'(1));
    chk("rst2_count_zero", 80'(out_count), 80'(0));
    expect_result(80'd2, 64'd2, 5'd1, 1'b0, 1'b0);
    send(64'd2, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    chk("scoreboard_drained", 80'(exp_q.size()), 80'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
